// File: rtl/proj_pkg.sv
// Shared types and constants for the perspective projection block and its divider.
package proj_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVX   = 2'd1,
        DIVY   = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam int DIVIDEND_W = 24;
    localparam int DIVISOR_W  = 17;
    localparam int SCR_W      = 11;

    localparam int DEF_FOCAL    = 256;
    localparam int DEF_Z_OFFSET = 512;
    localparam int DEF_Z_NEAR   = 16;
    localparam int DEF_SCREEN_W = 640;
    localparam int DEF_SCREEN_H = 480;

endpackage

// File: rtl/udiv_seq.sv
// Unsigned restoring divider, one quotient bit per step, MSB first.
module udiv_seq
    import proj_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    input  logic                  step,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic                  done
);

    // The dividend register shifts out its MSB while quotient bits shift in.
    logic [DIVIDEND_W-1:0] dq_q, dq_d;
    logic [DIVISOR_W:0]    rem_q, rem_d;
    logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
    logic [4:0]            cnt_q, cnt_d;

    logic [DIVISOR_W:0]    rem_shift;
    logic                  fits;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dq_q  <= '0;
            rem_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else begin
            dq_q  <= dq_d;
            rem_q <= rem_d;
            dvs_q <= dvs_d;
            cnt_q <= cnt_d;
        end
    end

    // quotient is the post-step value, so it is the final result while done is high.
    always_comb begin
        rem_shift = {rem_q[DIVISOR_W-1:0], dq_q[DIVIDEND_W-1]};
        fits      = (rem_shift >= {1'b0, dvs_q});
        quotient  = {dq_q[DIVIDEND_W-2:0], fits};
        done      = step && (cnt_q == 5'(DIVIDEND_W - 1));

        dq_d  = dq_q;
        rem_d = rem_q;
        dvs_d = dvs_q;
        cnt_d = cnt_q;
        if (load) begin
            dq_d  = dividend;
            rem_d = '0;
            dvs_d = divisor;
            cnt_d = '0;
        end else if (step) begin
            dq_d  = quotient;
            rem_d = fits ? (rem_shift - {1'b0, dvs_q}) : rem_shift;
            cnt_d = cnt_q + 5'd1;
        end
    end

endmodule

// File: rtl/perspective_proj.sv
// Pinhole perspective projection of a rotated vertex to clamped screen coordinates.
module perspective_proj
    import proj_pkg::*;
#(
    parameter int FOCAL    = DEF_FOCAL,
    parameter int Z_OFFSET = DEF_Z_OFFSET,
    parameter int Z_NEAR   = DEF_Z_NEAR,
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               iStart,
    input  logic signed [15:0] iX,
    input  logic signed [15:0] iY,
    input  logic signed [15:0] iZ,
    output logic               oBusy,
    output logic               oDone,
    output logic [SCR_W-1:0]   oSX,
    output logic [SCR_W-1:0]   oSY,
    output logic               oClip
);

    state_t                        state_q, state_d;
    logic                          xneg_q, xneg_d, yneg_q, yneg_d, near_q, near_d;
    logic [DIVIDEND_W-1:0]         ymag_q, ymag_d, qx_q, qx_d, qy_q, qy_d;
    logic signed [DIVISOR_W-1:0]   zc_q, zc_d;
    logic [SCR_W-1:0]              sx_q, sx_d, sy_q, sy_d;
    logic                          clip_q, clip_d, done_q, done_d;

    logic signed [DIVISOR_W-1:0]   zc_in;
    logic                          near_in;
    logic                          div_load, div_step, div_done;
    logic [DIVIDEND_W-1:0]         div_dividend, div_quot;
    logic [DIVISOR_W-1:0]          div_divisor;
    logic [SCR_W:0]                px, py;

    // |v| * FOCAL; widening to 17 bits first keeps -32768 exact.
    function automatic logic [DIVIDEND_W-1:0] mag_scale(input logic signed [15:0] v);
        logic signed [16:0] ve;
        logic [16:0]        a;
        ve = {v[15], v};
        a  = (ve < 0) ? 17'(-ve) : 17'(ve);
        return DIVIDEND_W'(a) * DIVIDEND_W'(FOCAL);
    endfunction

    // Returns {clamped, coordinate} for centre +/- magnitude.
    function automatic logic [SCR_W:0] place(input logic [DIVIDEND_W-1:0] mag, input logic sub,
                                             input int centre, input int limit);
        logic signed [DIVIDEND_W+1:0] off, v;
        off = $signed({2'b00, mag});
        v   = $signed((DIVIDEND_W+2)'(centre)) + (sub ? -off : off);
        if (v < 0)
            return {1'b1, {SCR_W{1'b0}}};
        else if (v > $signed((DIVIDEND_W+2)'(limit - 1)))
            return {1'b1, SCR_W'(limit - 1)};
        else
            return {1'b0, v[SCR_W-1:0]};
    endfunction

    udiv_seq u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (div_load),
        .dividend (div_dividend),
        .divisor  (div_divisor),
        .step     (div_step),
        .quotient (div_quot),
        .done     (div_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            xneg_q  <= 1'b0;
            yneg_q  <= 1'b0;
            near_q  <= 1'b0;
            ymag_q  <= '0;
            qx_q    <= '0;
            qy_q    <= '0;
            zc_q    <= '0;
            sx_q    <= '0;
            sy_q    <= '0;
            clip_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            xneg_q  <= xneg_d;
            yneg_q  <= yneg_d;
            near_q  <= near_d;
            ymag_q  <= ymag_d;
            qx_q    <= qx_d;
            qy_q    <= qy_d;
            zc_q    <= zc_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            clip_q  <= clip_d;
            done_q  <= done_d;
        end
    end

    assign zc_in   = $signed({iZ[15], iZ}) + $signed(DIVISOR_W'(Z_OFFSET));
    assign near_in = (zc_in < $signed(DIVISOR_W'(Z_NEAR)));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (iStart) state_d = near_in ? FINISH : DIVX;
            DIVX:    if (div_done) state_d = DIVY;
            DIVY:    if (div_done) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        xneg_d = xneg_q;
        yneg_d = yneg_q;
        near_d = near_q;
        ymag_d = ymag_q;
        qx_d   = qx_q;
        qy_d   = qy_q;
        zc_d   = zc_q;
        sx_d   = sx_q;
        sy_d   = sy_q;
        clip_d = clip_q;
        done_d = 1'b0;

        div_load     = 1'b0;
        div_step     = 1'b0;
        div_dividend = (state_q == IDLE) ? mag_scale(iX) : ymag_q;
        div_divisor  = (state_q == IDLE) ? $unsigned(zc_in) : $unsigned(zc_q);
        px           = place(qx_q, xneg_q, SCREEN_W / 2, SCREEN_W);
        py           = place(qy_q, !yneg_q, SCREEN_H / 2, SCREEN_H);

        case (state_q)
            IDLE: begin
                if (iStart) begin
                    xneg_d   = iX[15];
                    yneg_d   = iY[15];
                    ymag_d   = mag_scale(iY);
                    zc_d     = zc_in;
                    near_d   = near_in;
                    div_load = !near_in;
                end
            end
            DIVX: begin
                div_step = 1'b1;
                if (div_done) begin
                    qx_d     = div_quot;
                    div_load = 1'b1;
                end
            end
            DIVY: begin
                div_step = 1'b1;
                if (div_done) qy_d = div_quot;
            end
            FINISH: begin
                done_d = 1'b1;
                if (near_q) begin
                    sx_d   = '0;
                    sy_d   = '0;
                    clip_d = 1'b1;
                end else begin
                    sx_d   = px[SCR_W-1:0];
                    sy_d   = py[SCR_W-1:0];
                    clip_d = px[SCR_W] | py[SCR_W];
                end
            end
            default: ;
        endcase
    end

    assign oBusy = (state_q != IDLE);
    assign oDone = done_q;
    assign oSX   = sx_q;
    assign oSY   = sy_q;
    assign oClip = clip_q;

endmodule
